// File: rtl/int_arb_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM states,
// interrupt bit positions and the reserved-bit mask.
package int_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_TAKEN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int NUM_INT = 13;
  localparam int SWI0    = 0;
  localparam int HWI0    = 2;
  localparam int HWI_W   = 8;
  localparam int TI      = 11;
  localparam int IPI     = 12;

  // Bit 10 of ESTAT.IS is reserved and must never raise a request.
  localparam logic [NUM_INT-1:0] RSVD_MASK = 13'h1BFF;

endpackage

// File: rtl/int_arb_prio_enc.sv
// Fixed-priority encoder: the highest set bit of a 13-bit vector wins.
module int_prio_enc
  import int_arb_pkg::*;
(
  input  logic [NUM_INT-1:0] vec,
  output logic [3:0]         idx,
  output logic               valid
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      if (vec[i]) idx = 4'(i);
    end
    valid = |vec;
  end

endmodule

// File: rtl/int_arb.sv
// Interrupt arbiter: masks and prioritises pending interrupts and runs the
// request/ack/holdoff handshake. Define INT_ARB_HWI_SYNC_EN to synchronise HWI inputs.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no request outstanding, waiting for a qualified pending source
// ST_REQ   | int_req high, index tracks the current winner until ack
// ST_TAKEN | one-cycle int_taken pulse, index frozen
// ST_HOLD  | holdoff down-counter running, new requests suppressed
module int_arb
  import int_arb_pkg::*;
#(
  parameter int HOLDOFF = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_INT-1:0] ECFG_LIE,
  input  logic [NUM_INT-1:0] ESTAT_IS,
  input  logic               CRMD_IE,
  input  logic               int_ack,
  output logic               int_req,
  output logic [3:0]         int_idx,
  output logic               int_taken
);

  localparam logic [3:0] HOLD_LD = 4'(HOLDOFF - 1);

  state_t             state, state_nxt;
  logic [3:0]         cnt;
  logic [NUM_INT-1:0] is_eff;
  logic [NUM_INT-1:0] masked;
  logic [3:0]         win_idx;
  logic               win_vld;
  logic               any_pend;

`ifdef INT_ARB_HWI_SYNC_EN
  logic [HWI_W-1:0] hwi_s1, hwi_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwi_s1 <= '0;
      hwi_s2 <= '0;
    end else begin
      hwi_s1 <= ESTAT_IS[HWI0 +: HWI_W];
      hwi_s2 <= hwi_s1;
    end
  end

  assign is_eff = {ESTAT_IS[NUM_INT-1:HWI0+HWI_W], hwi_s2, ESTAT_IS[HWI0-1:SWI0]};
`else
  assign is_eff = ESTAT_IS;
`endif

  assign masked   = is_eff & ECFG_LIE & RSVD_MASK;
  assign any_pend = win_vld & CRMD_IE;

  int_prio_enc u_enc (
    .vec   (masked),
    .idx   (win_idx),
    .valid (win_vld)
  );

  // Index is captured while waiting and re-tracked in REQ; ack freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      int_idx <= '0;
    end else begin
      state <= state_nxt;
      if (any_pend && (state == ST_IDLE || (state == ST_REQ && !int_ack)))
        int_idx <= win_idx;
      if (state == ST_TAKEN)
        cnt <= HOLD_LD;
      else if (state == ST_HOLD && cnt != '0)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_pend) state_nxt = ST_REQ;
      ST_REQ: begin
        if (int_ack)       state_nxt = ST_TAKEN;
        else if (!any_pend) state_nxt = ST_IDLE;
      end
      ST_TAKEN: state_nxt = ST_HOLD;
      ST_HOLD:  if (cnt == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    int_req   = (state == ST_REQ);
    int_taken = (state == ST_TAKEN);
  end

endmodule

// File: tb/tb_int_arb.sv
// Scoreboard bench for int_arb: directed vectors push the expected outputs,
// a monitor pops and compares one entry per clock.
module tb_int_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] lie, is;
  logic        ie, ack;
  logic        int_req, int_taken;
  logic [3:0]  int_idx;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       req;
    logic [3:0] idx;
    logic       taken;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  int_arb #(.HOLDOFF(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ECFG_LIE  (lie),
    .ESTAT_IS  (is),
    .CRMD_IE   (ie),
    .int_ack   (ack),
    .int_req   (int_req),
    .int_idx   (int_idx),
    .int_taken (int_taken)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      cmp({e.name, ".req"},   {3'b0, int_req},   {3'b0, e.req});
      cmp({e.name, ".idx"},   int_idx,           e.idx);
      cmp({e.name, ".taken"}, {3'b0, int_taken}, {3'b0, e.taken});
    end
  end

  // Drive inputs (at posedge+2), push expected outputs after the next edge.
  task automatic step(input logic [12:0] l, input logic [12:0] s, input logic e_ie,
                      input logic a, input logic x_req, input logic [3:0] x_idx,
                      input logic x_tk, input string name);
    exp_t e;
    lie = l; is = s; ie = e_ie; ack = a;
    e.req = x_req; e.idx = x_idx; e.taken = x_tk; e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    lie = '0; is = '0; ie = 1'b0; ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst.req",   {3'b0, int_req},   4'd0);
    cmp("rst.idx",   int_idx,           4'd0);
    cmp("rst.taken", {3'b0, int_taken}, 4'd0);
    #1;
    rst_n = 1'b1;

    // Timer interrupt: request, ack, then HOLDOFF+1 suppressed cycles
    step(13'h0800, 13'h0800, 1, 0, 1, 11, 0, "ti_req");
    step(13'h0800, 13'h0800, 1, 1, 0, 11, 1, "ti_taken");
    step(13'h0800, 13'h0800, 1, 0, 0, 11, 0, "ti_hold3");
    step(13'h0800, 13'h0800, 1, 1, 0, 11, 0, "ti_hold2_ackign");
    step(13'h0800, 13'h0800, 1, 0, 0, 11, 0, "ti_hold1");
    step(13'h0800, 13'h0800, 1, 0, 0, 11, 0, "ti_hold0");
    step(13'h0800, 13'h0800, 1, 0, 0, 11, 0, "ti_idle");
    step(13'h0800, 13'h0800, 1, 0, 1, 11, 0, "ti_rereq");
    step(13'h0800, 13'h0000, 1, 0, 0, 11, 0, "ti_withdraw");

    // Higher priority arrival replaces index while in REQ; ack freezes it
    step(13'h1FFF, 13'h0004, 1, 0, 1, 2,  0, "pr_hwi0");
    step(13'h1FFF, 13'h1004, 1, 0, 1, 12, 0, "pr_ipi");
    step(13'h1FFF, 13'h1004, 1, 1, 0, 12, 1, "pr_taken");
    step(13'h1FFF, 13'h0004, 1, 0, 0, 12, 0, "pr_frozen");
    step(13'h1FFF, 13'h0000, 1, 0, 0, 12, 0, "pr_hold2");
    step(13'h1FFF, 13'h0000, 1, 0, 0, 12, 0, "pr_hold1");
    step(13'h1FFF, 13'h0000, 1, 0, 0, 12, 0, "pr_hold0");
    step(13'h1FFF, 13'h0000, 1, 0, 0, 12, 0, "pr_idle");

    // Reserved bit and global disable never request
    step(13'h1FFF, 13'h0400, 1, 0, 0, 12, 0, "rsvd_a");
    step(13'h1FFF, 13'h0400, 1, 0, 0, 12, 0, "rsvd_b");
    step(13'h1FFF, 13'h0001, 0, 0, 0, 12, 0, "ie_off_a");
    step(13'h1FFF, 13'h0001, 0, 1, 0, 12, 0, "ie_off_b");

    // Withdraw vs. ack in the same cycle as the withdraw
    step(13'h1FFF, 13'h0002, 1, 0, 1, 1, 0, "wd_req");
    step(13'h1FFF, 13'h0000, 1, 0, 0, 1, 0, "wd_idle");
    step(13'h1FFF, 13'h0002, 1, 0, 1, 1, 0, "wa_req");
    step(13'h1FFF, 13'h0000, 1, 1, 0, 1, 1, "wa_taken");
    step(13'h1FFF, 13'h0000, 1, 0, 0, 1, 0, "wa_hold3");
    step(13'h1FFF, 13'h0000, 1, 0, 0, 1, 0, "wa_hold2");

    // Reset in the middle of HOLD with a source pending
    lie = 13'h1FFF; is = 13'h0800; ie = 1'b1; ack = 1'b0;
    rst_n = 1'b0;
    #1;
    cmp("hrst.req",   {3'b0, int_req},   4'd0);
    cmp("hrst.idx",   int_idx,           4'd0);
    cmp("hrst.taken", {3'b0, int_taken}, 4'd0);
    #1;
    step(13'h1FFF, 13'h0800, 1, 0, 0, 0, 0, "hrst_cyc1");
    step(13'h1FFF, 13'h0800, 1, 0, 0, 0, 0, "hrst_cyc2");
    rst_n = 1'b1;
    step(13'h1FFF, 13'h0800, 1, 0, 1, 11, 0, "post_rst_req");
    step(13'h1FFF, 13'h0800, 1, 1, 0, 11, 1, "post_rst_taken");
    step(13'h1FFF, 13'h0000, 1, 0, 0, 11, 0, "post_rst_hold");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
